// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall hold, flush-to-bubble and invalid-slot control squash.
// Optional bubble counter output is enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_reg #(
   parameter int unsigned CTRL_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [31:0]       id_pc,
   input  logic [31:0]       id_rs_data,
   input  logic [31:0]       id_rt_data,
   input  logic [31:0]       id_imm,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic [1:0]        id_regdst,
   input  logic [1:0]        id_fwd_a,
   input  logic [1:0]        id_fwd_b,
   input  logic [CTRL_W-1:0] id_ctrl,
   output logic              ex_valid,
   output logic [31:0]       ex_pc,
   output logic [31:0]       ex_rs_data,
   output logic [31:0]       ex_rt_data,
   output logic [31:0]       ex_imm,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic [1:0]        ex_regdst,
   output logic [1:0]        ex_fwd_a,
   output logic [1:0]        ex_fwd_b,
   output logic [CTRL_W-1:0] ex_ctrl
`ifdef ID_EX_BUBBLE_CNT_EN
   ,
   output logic [31:0]       ex_bubble_cnt
`endif
);

   localparam int unsigned XLEN   = 32;
   localparam int unsigned RIDX_W = 5;
   localparam int unsigned SEL_W  = 2;

   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   rs_data;
      logic [XLEN-1:0]   rt_data;
      logic [XLEN-1:0]   imm;
      logic [RIDX_W-1:0] rs;
      logic [RIDX_W-1:0] rt;
      logic [RIDX_W-1:0] rd;
      logic [SEL_W-1:0]  regdst;
      logic [SEL_W-1:0]  fwd_a;
      logic [SEL_W-1:0]  fwd_b;
      logic [CTRL_W-1:0] ctrl;
   } ex_pl_t;

   ex_pl_t pl_d, pl_q;

   // Priority below reset: flush > stall > load; invalid slots never carry control.
   always_comb begin
      pl_d = pl_q;
      if (flush) begin
         pl_d = '0;
      end else if (!stall) begin
         pl_d.valid   = id_valid;
         pl_d.pc      = id_pc;
         pl_d.rs_data = id_rs_data;
         pl_d.rt_data = id_rt_data;
         pl_d.imm     = id_imm;
         pl_d.rs      = id_rs;
         pl_d.rt      = id_rt;
         pl_d.rd      = id_rd;
         pl_d.regdst  = id_regdst;
         pl_d.fwd_a   = id_fwd_a;
         pl_d.fwd_b   = id_fwd_b;
         pl_d.ctrl    = id_valid ? id_ctrl : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pl_q <= '0;
      end else begin
         pl_q <= pl_d;
      end
   end

   assign ex_valid   = pl_q.valid;
   assign ex_pc      = pl_q.pc;
   assign ex_rs_data = pl_q.rs_data;
   assign ex_rt_data = pl_q.rt_data;
   assign ex_imm     = pl_q.imm;
   assign ex_rs      = pl_q.rs;
   assign ex_rt      = pl_q.rt;
   assign ex_rd      = pl_q.rd;
   assign ex_regdst  = pl_q.regdst;
   assign ex_fwd_a   = pl_q.fwd_a;
   assign ex_fwd_b   = pl_q.fwd_b;
   assign ex_ctrl    = pl_q.ctrl;

`ifdef ID_EX_BUBBLE_CNT_EN
   localparam int unsigned CNT_W = 32;

   logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
   logic             load_bubble_c;

   // Saturating count of edges that load a bubble; held edges are not counted.
   always_comb begin
      load_bubble_c = flush | (~stall & ~id_valid);
      bubble_cnt_d  = bubble_cnt_q;
      if (load_bubble_c && (bubble_cnt_q != '1)) begin
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt_q <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign ex_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: directed stimulus pushes hand-computed expectations,
// a monitor pops and compares one entry after every clock edge.
module tb_id_ex_reg;

   localparam logic [31:0] OTH_RT_DATA = 32'h1111_2222;
   localparam logic [31:0] OTH_IMM     = 32'h0000_FFFC;
   localparam logic [4:0]  OTH_RS      = 5'd3;
   localparam logic [4:0]  OTH_RT      = 5'd4;
   localparam logic [1:0]  OTH_FWD_A   = 2'b11;
   localparam logic [1:0]  OTH_FWD_B   = 2'b01;

   logic        clk;
   logic        rst, stall, flush, id_valid;
   logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [1:0]  id_regdst, id_fwd_a, id_fwd_b;
   logic [11:0] id_ctrl;
   logic        ex_valid;
   logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [1:0]  ex_regdst, ex_fwd_a, ex_fwd_b;
   logic [11:0] ex_ctrl;
`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0] ex_bubble_cnt;
`endif

   id_ex_reg #(.CTRL_W(12)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_regdst(id_regdst),
      .id_fwd_a(id_fwd_a), .id_fwd_b(id_fwd_b), .id_ctrl(id_ctrl),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
      .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regdst(ex_regdst),
      .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .ex_ctrl(ex_ctrl)
`ifdef ID_EX_BUBBLE_CNT_EN
      , .ex_bubble_cnt(ex_bubble_cnt)
`endif
   );

   typedef struct {
      string       nm;
      bit          valid;
      logic [31:0] pc;
      logic [31:0] rs_data;
      logic [4:0]  rd;
      logic [1:0]  regdst;
      logic [11:0] ctrl;
      bit          others;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
      end
   endtask

   // Monitor: one expectation per clock edge, sampled 1ns after the edge.
   always @(posedge clk) begin
      #1;
      if (sb.size() != 0) begin
         mon_e = sb.pop_front();
         chk(mon_e.nm, "valid",   32'(ex_valid),   32'(mon_e.valid));
         chk(mon_e.nm, "pc",      ex_pc,           mon_e.pc);
         chk(mon_e.nm, "rs_data", ex_rs_data,      mon_e.rs_data);
         chk(mon_e.nm, "rd",      32'(ex_rd),      32'(mon_e.rd));
         chk(mon_e.nm, "regdst",  32'(ex_regdst),  32'(mon_e.regdst));
         chk(mon_e.nm, "ctrl",    32'(ex_ctrl),    32'(mon_e.ctrl));
         chk(mon_e.nm, "rt_data", ex_rt_data,      mon_e.others ? OTH_RT_DATA : 32'h0);
         chk(mon_e.nm, "imm",     ex_imm,          mon_e.others ? OTH_IMM : 32'h0);
         chk(mon_e.nm, "rs",      32'(ex_rs),      mon_e.others ? 32'(OTH_RS) : 32'h0);
         chk(mon_e.nm, "rt",      32'(ex_rt),      mon_e.others ? 32'(OTH_RT) : 32'h0);
         chk(mon_e.nm, "fwd_a",   32'(ex_fwd_a),   mon_e.others ? 32'(OTH_FWD_A) : 32'h0);
         chk(mon_e.nm, "fwd_b",   32'(ex_fwd_b),   mon_e.others ? 32'(OTH_FWD_B) : 32'h0);
`ifdef ID_EX_BUBBLE_CNT_EN
         chk(mon_e.nm, "bubble_cnt", ex_bubble_cnt, mon_e.cnt);
`endif
      end
   end

   // Drive one cycle of inputs at the falling edge and queue what EX must show after the next rising edge.
   task automatic step(input string nm, input bit r, input bit s, input bit f, input bit v,
                       input logic [31:0] pc, input logic [31:0] rsd, input logic [4:0] rd,
                       input logic [1:0] rdst, input logic [11:0] ctrl,
                       input bit ev, input logic [31:0] epc, input logic [31:0] ersd,
                       input logic [4:0] erd, input logic [1:0] erdst, input logic [11:0] ectrl,
                       input bit eoth, input logic [31:0] ecnt);
      exp_t e;
      @(negedge clk);
      rst = r; stall = s; flush = f; id_valid = v;
      id_pc = pc; id_rs_data = rsd; id_rd = rd; id_regdst = rdst; id_ctrl = ctrl;
      e.nm = nm; e.valid = ev; e.pc = epc; e.rs_data = ersd; e.rd = erd;
      e.regdst = erdst; e.ctrl = ectrl; e.others = eoth; e.cnt = ecnt;
      sb.push_back(e);
   endtask

   task automatic step_zero(input string nm, input bit r, input bit s, input bit f, input bit v,
                            input logic [31:0] pc, input logic [31:0] rsd, input logic [4:0] rd,
                            input logic [1:0] rdst, input logic [11:0] ctrl, input logic [31:0] ecnt);
      step(nm, r, s, f, v, pc, rsd, rd, rdst, ctrl, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 12'h000, 1'b0, ecnt);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b1;
      id_pc = 32'h0000_1234; id_rs_data = 32'hAAAA_5555; id_rd = 5'd7;
      id_regdst = 2'b01; id_ctrl = 12'hFFF;
      id_rt_data = OTH_RT_DATA; id_imm = OTH_IMM; id_rs = OTH_RS; id_rt = OTH_RT;
      id_fwd_a = OTH_FWD_A; id_fwd_b = OTH_FWD_B;

      step_zero("rst0", 1, 0, 0, 1, 32'h0000_1234, 32'hAAAA_5555, 5'd7, 2'b01, 12'hFFF, 32'd0);
      step_zero("rst1", 1, 0, 0, 1, 32'h0000_1234, 32'hAAAA_5555, 5'd7, 2'b01, 12'hFFF, 32'd0);
      step("load", 0, 0, 0, 1, 32'h0040_0010, 32'hDEAD_BEEF, 5'd9, 2'b01, 12'h003,
           1, 32'h0040_0010, 32'hDEAD_BEEF, 5'd9, 2'b01, 12'h003, 1, 32'd0);
      step("stall0", 0, 1, 0, 1, 32'h0040_0014, 32'h0000_0001, 5'd1, 2'b00, 12'hFFF,
           1, 32'h0040_0010, 32'hDEAD_BEEF, 5'd9, 2'b01, 12'h003, 1, 32'd0);
      step("stall1", 0, 1, 0, 1, 32'h0040_0018, 32'h0000_0002, 5'd2, 2'b10, 12'hFFF,
           1, 32'h0040_0010, 32'hDEAD_BEEF, 5'd9, 2'b01, 12'h003, 1, 32'd0);
      step("stall2", 0, 1, 0, 1, 32'h0040_001C, 32'h0000_0003, 5'd10, 2'b00, 12'h005,
           1, 32'h0040_0010, 32'hDEAD_BEEF, 5'd9, 2'b01, 12'h003, 1, 32'd0);
      step("unstall", 0, 0, 0, 1, 32'h0040_001C, 32'h0000_0003, 5'd10, 2'b00, 12'h005,
           1, 32'h0040_001C, 32'h0000_0003, 5'd10, 2'b00, 12'h005, 1, 32'd0);
      step("b2b", 0, 0, 0, 1, 32'h0040_0020, 32'h1234_5678, 5'd31, 2'b10, 12'h080,
           1, 32'h0040_0020, 32'h1234_5678, 5'd31, 2'b10, 12'h080, 1, 32'd0);
      step_zero("flush_stall", 0, 1, 1, 1, 32'h0040_0024, 32'h5555_AAAA, 5'd8, 2'b01, 12'hFFF, 32'd1);
      step("invalid", 0, 0, 0, 0, 32'h0040_0024, 32'hCAFE_F00D, 5'd5, 2'b11, 12'h003,
           0, 32'h0040_0024, 32'hCAFE_F00D, 5'd5, 2'b11, 12'h000, 1, 32'd2);
      step("stall_inv", 0, 1, 0, 0, 32'h0040_0028, 32'h0BAD_0BAD, 5'd6, 2'b00, 12'h003,
           0, 32'h0040_0024, 32'hCAFE_F00D, 5'd5, 2'b11, 12'h000, 1, 32'd2);
      step_zero("flush", 0, 0, 1, 1, 32'h0040_0028, 32'h0BAD_0BAD, 5'd6, 2'b00, 12'h003, 32'd3);
      step("load2", 0, 0, 0, 1, 32'h0040_002C, 32'h7777_8888, 5'd12, 2'b01, 12'h801,
           1, 32'h0040_002C, 32'h7777_8888, 5'd12, 2'b01, 12'h801, 1, 32'd3);
      step_zero("rst_stall", 1, 1, 0, 1, 32'h0040_0030, 32'h9999_0000, 5'd13, 2'b01, 12'h0F0, 32'd0);
      step_zero("rst_flush", 1, 0, 1, 1, 32'h0040_0034, 32'h9999_1111, 5'd14, 2'b01, 12'h0F0, 32'd0);
      step_zero("post_rst_stall", 0, 1, 0, 1, 32'h0040_0038, 32'h9999_2222, 5'd15, 2'b10, 12'h0F0, 32'd0);
      step("post_rst_load", 0, 0, 0, 1, 32'h0040_003C, 32'h9999_3333, 5'd16, 2'b10, 12'h0F0,
           1, 32'h0040_003C, 32'h9999_3333, 5'd16, 2'b10, 12'h0F0, 1, 32'd0);

`ifdef ID_EX_BUBBLE_CNT_EN
      @(negedge clk);
      dut.bubble_cnt_q = 32'hFFFF_FFFE;
      step_zero("sat0", 0, 0, 1, 1, 32'h0040_0040, 32'h1, 5'd1, 2'b01, 12'h001, 32'hFFFF_FFFF);
      step_zero("sat1", 0, 0, 1, 1, 32'h0040_0044, 32'h2, 5'd2, 2'b01, 12'h001, 32'hFFFF_FFFF);
      step_zero("sat2", 0, 0, 1, 1, 32'h0040_0048, 32'h3, 5'd3, 2'b01, 12'h001, 32'hFFFF_FFFF);
      step("sat_inv", 0, 0, 0, 0, 32'h0040_004C, 32'h4, 5'd4, 2'b01, 12'h001,
           0, 32'h0040_004C, 32'h4, 5'd4, 2'b01, 12'h000, 1, 32'hFFFF_FFFF);
`endif

      repeat (3) @(posedge clk);
      #2;
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
